// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle. Divide-by-zero and signed overflow complete in a single cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  wa,
    output logic        we
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              sa_q;
    logic              sb_q;
    logic [XLEN-1:0]   opnd_q;
    logic [4:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;

    // Operand decode at start
    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_val;

    always_comb begin
        a_signed    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa          = a_signed && a[XLEN-1];
        sb          = b_signed && b[XLEN-1];
        mag_a       = sa ? XLEN'(-a) : a;
        mag_b       = sb ? XLEN'(-b) : b;
        div_zero    = op[2] && (b == '0);
        div_ovf     = ((op == 3'b100) || (op == 3'b110)) &&
                      (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        special_val = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : 32'h8000_0000);
    end

    // One iteration step plus the sign-corrected result of the final step
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN:0]     rem_shift;
    logic              div_ok;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   quo_fin;
    logic [XLEN-1:0]   rem_fin;
    logic [XLEN-1:0]   calc_result;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        prod_fin  = (sa_q ^ sb_q) ? (2*XLEN)'(-mul_next) : mul_next;
        rem_shift = {rem, acc[XLEN-1]};
        div_ok    = rem_shift >= {1'b0, opnd_q};
        div_diff  = XLEN'(rem_shift - {1'b0, opnd_q});
        rem_next  = div_ok ? div_diff : rem_shift[XLEN-1:0];
        quo_next  = {acc[XLEN-2:0], div_ok};
        quo_fin   = (sa_q ^ sb_q) ? XLEN'(-quo_next) : quo_next;
        rem_fin   = sa_q ? XLEN'(-rem_next) : rem_next;
        if (op_q[2])
            calc_result = op_q[1] ? rem_fin : quo_fin;
        else
            calc_result = (op_q == 3'b000) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            we     <= 1'b0;
            result <= '0;
            wa     <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            opnd_q <= '0;
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q <= op;
                        rd_q <= rd;
                        sa_q <= sa;
                        sb_q <= sb;
                        busy <= 1'b1;
                        cnt  <= '0;
                        rem  <= '0;
                        if (div_zero || div_ovf) begin
                            state  <= DONE;
                            result <= special_val;
                            wa     <= rd;
                            done   <= 1'b1;
                            we     <= 1'b1;
                        end else begin
                            state <= CALC;
                            // Multiply adds |a| under |b| bits; divide subtracts |b| from |a| bits
                            opnd_q <= op[2] ? mag_b : mag_a;
                            acc    <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (op_q[2]) begin
                            acc <= {{XLEN{1'b0}}, quo_next};
                            rem <= rem_next;
                        end else begin
                            acc <= mul_next;
                        end
                        if (cnt == 5'd31) begin
                            state  <= DONE;
                            result <= calc_result;
                            wa     <= rd_q;
                            done   <= 1'b1;
                            we     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
